// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding, CRC constants and counter sizing for the CCFF chain loader (VERIFY exists only with CCFF_READBACK_EN)
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef CCFF_READBACK_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// ccff_crc16: serial CRC-16-CCITT, one bit per cycle; crc_nxt lets the owner compare against the value including this cycle's bit
module ccff_crc16
    import ccff_loader_pkg::*;
(
    input  logic        CK,
    input  logic        RST,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc,
    output logic [15:0] crc_nxt
);

    always_comb crc_nxt = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);

    always_ff @(posedge CK) begin
        if (RST || clr)
            crc <= CRC16_INIT;
        else if (en)
            crc <= crc_nxt;
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises a byte stream onto the CCFF chain, MSB first, one bit per cycle.
// Define CCFF_READBACK_EN to add a CRC-checked rotate-verify pass after the load.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int BYTE_W    = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = cnt_w(CHAIN_LEN);
    localparam int HW = cnt_w(BYTE_W);
    localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);
    localparam logic [HW-1:0] REST   = HW'(BYTE_W - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     hcnt;
    logic [BYTE_W-1:0] hold;
    logic              head_q;
    logic              err_q;

    // hcnt counts bits still waiting behind the one currently on ccff_head
    assign byte_ready = (state == S_LOAD) && (hcnt == '0) && (cnt != LEN);
    assign done       = (state == S_DONE);
    assign err        = err_q;

`ifdef CCFF_READBACK_EN
    logic        go;
    logic [15:0] crc_load;
    logic [15:0] crc_rot_nxt;
    logic [15:0] unused_load_nxt;
    logic [15:0] unused_rot;

    assign go        = start && !abort && (state == S_IDLE || state == S_DONE);
    assign busy      = (state == S_LOAD) || (state == S_VERIFY);
    assign ccff_head = (state == S_VERIFY) ? ccff_tail : head_q;

    ccff_crc16 u_crc_load (
        .CK      (CK),
        .RST     (RST),
        .clr     (go),
        .en      ((state == S_LOAD) && prog_en),
        .din     (head_q),
        .crc     (crc_load),
        .crc_nxt (unused_load_nxt)
    );

    ccff_crc16 u_crc_rot (
        .CK      (CK),
        .RST     (RST),
        .clr     (go),
        .en      (state == S_VERIFY),
        .din     (ccff_tail),
        .crc     (unused_rot),
        .crc_nxt (crc_rot_nxt)
    );
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign busy        = (state == S_LOAD);
    assign ccff_head   = head_q;
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hcnt    <= '0;
            hold    <= '0;
            head_q  <= 1'b0;
            prog_en <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort) begin
            state   <= S_IDLE;
            prog_en <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (cnt == LEN) begin
`ifdef CCFF_READBACK_EN
                        state   <= S_VERIFY;
                        prog_en <= 1'b1;
                        cnt     <= '0;
`else
                        state   <= S_DONE;
                        prog_en <= 1'b0;
`endif
                    end else if (hcnt != '0) begin
                        head_q  <= hold[BYTE_W-1];
                        hold    <= hold << 1;
                        hcnt    <= hcnt - 1'b1;
                        prog_en <= 1'b1;
                        cnt     <= cnt + 1'b1;
                    end else if (byte_valid) begin
                        head_q  <= byte_data[BYTE_W-1];
                        hold    <= byte_data << 1;
                        hcnt    <= REST;
                        prog_en <= 1'b1;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        prog_en <= 1'b0;
                    end
                end
`ifdef CCFF_READBACK_EN
                S_VERIFY: begin
                    if (cnt == LEN_M1) begin
                        state   <= S_DONE;
                        prog_en <= 1'b0;
                        err_q   <= (crc_load != crc_rot_nxt);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    if (start) begin
                        state   <= S_LOAD;
                        cnt     <= '0;
                        hcnt    <= '0;
                        hold    <= '0;
                        prog_en <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table, hand-written and random loads against a bit-stream model of a 20-cell chain
module tb_ccff_chain_loader;

    localparam int N  = 20;
    localparam int BW = 8;
`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam logic [N-1:0] FLIP7 = N'(1 << 7);

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready, ccff_head, ccff_tail, prog_en, busy, done, err;
    logic [N-1:0]  chain = '0;
    logic          flip_req = 1'b0;
    int            tests = 0;
    int            fails = 0;

    ccff_chain_loader #(.CHAIN_LEN(N), .BYTE_W(BW)) dut (
        .CK         (CK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .prog_en    (prog_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CK = ~CK;

    assign ccff_tail = chain[N-1];

    always @(posedge CK)
        if (prog_en)
            chain <= {chain[N-2:0], ccff_head} ^ (flip_req ? FLIP7 : '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // first N bits of the MSB-first stream; the first bit issued ends up in the tail cell
    function automatic logic [N-1:0] model_chain(input logic [23:0] b);
        bit q[$];
        logic [N-1:0] r;
        for (int i = 0; i < 3; i++)
            for (int j = BW - 1; j >= 0; j--)
                q.push_back(b[BW*(2-i)+j]);
        for (int i = 0; i < N; i++)
            r[N-1-i] = q[i];
        return r;
    endfunction

    // a gap g after a transfer only costs cycles beyond the BW-1 remaining bits of that byte
    function automatic int model_lat(input int g0, input int g1, input int g2);
        return N + 1 + g0 + (g1 > BW - 1 ? g1 - (BW - 1) : 0) + (g2 > BW - 1 ? g2 - (BW - 1) : 0) + RB * N;
    endfunction

    task automatic run_load(input logic [23:0] bytes, input int g0, input int g1, input int g2,
                            input int flip_at, input int intr_at, input bit intr_rst, input int start_at,
                            output int lat, output int pes);
        int  bi = 0;
        int  gl = g0;
        int  c = 0;
        int  sh;
        bit  xfer;
        lat = -1;
        pes = 0;
        start = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
        while (c < 300) begin
            sh = (bi < 3) ? 16 - BW * bi : 0;
            byte_valid = (bi < 3) && (gl == 0);
            byte_data = BW'(bytes >> sh);
            start = (c == start_at);
            abort = (c == intr_at) && !intr_rst;
            RST = (c == intr_at) && intr_rst;
            flip_req = (c == flip_at);
            @(negedge CK);
            xfer = byte_valid && byte_ready;
            pes += int'(prog_en);
            @(posedge CK);
            #1;
            c++;
            if (xfer) begin
                bi++;
                gl = (bi == 1) ? g1 : (bi == 2) ? g2 : 0;
            end else if (gl > 0) begin
                gl--;
            end
            if (c - 1 == intr_at) begin
                chk(intr_rst ? "rst_busy" : "abort_busy", busy, 0);
                chk(intr_rst ? "rst_prog_en" : "abort_prog_en", prog_en, 0);
                chk(intr_rst ? "rst_done" : "abort_done", done, 0);
                if (intr_rst)
                    chk("rst_err", err, 0);
                break;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        RST = 1'b0;
        flip_req = 1'b0;
    endtask

    typedef struct {
        logic [23:0]  bytes;
        int           g0, g1, g2;
        int           flip_at;
        logic [N-1:0] chain;
        int           lat;
        bit           err;
    } vec_t;

    vec_t tbl[6];
    int   lat, pes;

    task automatic check_load(input string name, input vec_t v, input int l, input int p);
        chk({name, "_lat"}, l, v.lat);
        chk({name, "_prog_en_cycles"}, p, N * (1 + RB));
        chk({name, "_chain"}, chain, v.chain);
        chk({name, "_err"}, err, v.err);
    endtask

    initial begin
        tbl[0] = '{24'hA53CF0, 0, 0, 0, -1, 20'hA53CF, N + 1 + RB * N, 1'b0};
        tbl[1] = '{24'hA53CF0, 0, 12, 0, -1, 20'hA53CF, N + 6 + RB * N, 1'b0};
        tbl[2] = '{24'h123456, 3, 0, 0, -1, 20'h12345, N + 4 + RB * N, 1'b0};
        tbl[3] = '{24'hA53CF0, 0, 0, 0, N + 1, 20'hA53CF ^ 20'h00040, 2 * N + 1, 1'b1};
        tbl[4] = '{24'h000000, 0, 0, 0, -1, 20'h00000, N + 1 + RB * N, 1'b0};
        tbl[5] = '{24'hFFFFFF, 0, 0, 10, -1, 20'hFFFFF, N + 4 + RB * N, 1'b0};

        repeat (2) @(posedge CK);
        @(negedge CK);
        chk("reset_byte_ready", byte_ready, 0);
        chk("reset_ccff_head", ccff_head, 0);
        chk("reset_prog_en", prog_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        @(posedge CK);
        #1;
        RST = 1'b0;

        // first byte: MSB on the head, with prog_en, right after the accepting edge
        start = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        @(negedge CK);
        chk("first_ready", byte_ready, 1);
        chk("first_prog_en_before", prog_en, 0);
        chk("first_busy", busy, 1);
        @(posedge CK);
        #1;
        byte_valid = 1'b0;
        @(negedge CK);
        chk("first_msb_head", ccff_head, 1);
        chk("first_msb_prog_en", prog_en, 1);
        chk("first_ready_after", byte_ready, 0);
        @(posedge CK);
        @(negedge CK);
        chk("second_bit_head", ccff_head, 0);
        abort = 1'b1;
        @(posedge CK);
        #1;
        abort = 1'b0;
        chk("first_abort_busy", busy, 0);

        foreach (tbl[i]) begin
            if (tbl[i].flip_at >= 0 && RB == 0)
                continue;
            run_load(tbl[i].bytes, tbl[i].g0, tbl[i].g1, tbl[i].g2, tbl[i].flip_at, -1, 1'b0, -1, lat, pes);
            check_load($sformatf("tbl%0d", i), tbl[i], lat, pes);
        end

        // start and abort together from DONE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);

        run_load(24'h5A5A5A, 0, 0, 0, -1, 9, 1'b0, -1, lat, pes);
        run_load(tbl[0].bytes, 0, 0, 0, -1, -1, 1'b0, -1, lat, pes);
        check_load("after_abort", tbl[0], lat, pes);

        run_load(24'h5A5A5A, 0, 0, 0, -1, 9, 1'b1, -1, lat, pes);
        run_load(tbl[0].bytes, 0, 0, 0, -1, -1, 1'b0, -1, lat, pes);
        check_load("after_rst", tbl[0], lat, pes);

        run_load(tbl[0].bytes, 0, 0, 0, -1, -1, 1'b0, 5, lat, pes);
        check_load("ignored_start", tbl[0], lat, pes);

        for (int k = 0; k < 20; k++) begin
            vec_t v;
            v.bytes = 24'($urandom);
            v.g0 = $urandom_range(0, 4);
            v.g1 = $urandom_range(0, 12);
            v.g2 = $urandom_range(0, 12);
            v.flip_at = -1;
            v.chain = model_chain(v.bytes);
            v.lat = model_lat(v.g0, v.g1, v.g2);
            v.err = 1'b0;
            run_load(v.bytes, v.g0, v.g1, v.g2, -1, -1, 1'b0, -1, lat, pes);
            check_load($sformatf("rand%0d", k), v, lat, pes);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequences the serial configuration-flip-flop (CCFF) chain built from `DFF`/`DFFSRQ` cells. It accepts a bitstream as bytes over a valid/ready handshake and serialises them onto the chain head, one bit per cycle, gating the chain with a shift enable. It counts bits and signals completion. Optionally, it rotates the chain once more to verify the contents by CRC. It sits between the host-side bitstream source and the fabric configuration chain.

## Interface
- `CHAIN_LEN`, default 1024: number of CCFF cells in the chain; must be ≥1.
- `BYTE_W`, default 8: width of a bitstream byte.

- `CK` in 1: single clock; the chain also shifts on `CK`.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load; only honoured in IDLE or DONE.
- `abort` in 1: returns the block to IDLE from any state.
- `byte_data` in `BYTE_W`: bitstream byte, MSB shifted first.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_ready` out 1: the block accepts `byte_data` this cycle.
- `ccff_head` out 1: serial data into the chain.
- `ccff_tail` in 1: Q of the last chain cell.
- `prog_en` out 1: the chain shifts at the next `CK` rise when this is high.
- `busy` out 1: high in LOAD or VERIFY.
- `done` out 1: high in DONE (level).
- `err` out 1: verify mismatch; level, held through DONE.

## Operation
- States are IDLE, LOAD, VERIFY (present only when the readback feature is compiled in) and DONE.
- IDLE → LOAD on `start`. The bit counter clears, the holding register empties, and `err` clears.
- LOAD:
  - `byte_ready` = holding register empty, or holding register on its last valid bit, AND bits issued < `CHAIN_LEN`.
  - A transfer occurs at a `CK` edge when `byte_valid & byte_ready`.
  - Each cycle with a bit available: `ccff_head` = current bit, `prog_en` = 1, and the bit counter increments.
  - With no bit available (`byte_valid` low): `prog_en` = 0 and the chain holds (stall).
  - Last byte: when `CHAIN_LEN` is not a multiple of `BYTE_W`, only the top `CHAIN_LEN mod BYTE_W` bits are used and the rest are discarded.
  - Once the counter reaches `CHAIN_LEN`, the next state is VERIFY if compiled in, otherwise DONE.
- VERIFY: see Configuration.
- DONE: `prog_en` = 0. `start` restarts a load (→ LOAD). `byte_ready` = 0.
- `abort` in any state → IDLE next cycle with `prog_en` = 0. Chain contents are then undefined and `done` = 0.
- `start` while in LOAD or VERIFY is ignored.
- `start` and `abort` in the same cycle: `abort` wins.
- Bit counter width is `$clog2(CHAIN_LEN+1)`. It never wraps because issue stops at `CHAIN_LEN`.

## Timing
- Reset values: state = IDLE; `byte_ready`, `ccff_head`, `prog_en`, `busy`, `done`, `err` = 0; counters and holding register = 0.
- `ccff_head` and `prog_en` are registered in LOAD.
  - A byte accepted at edge k drives its MSB on `ccff_head` with `prog_en` = 1 after edge k.
  - The chain captures that bit at edge k+1.
- With continuous `byte_valid`, throughput is 1 bit/cycle with no bubble between bytes.
- A load takes `CHAIN_LEN` + 1 cycles from `start` to `done` (without verify), with no stalls.
- `RST` mid-load behaves as `abort` and additionally clears `err`.

## Configuration
- Macro `CCFF_READBACK_EN`.
- Defined:
  - During LOAD, a serial CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates every bit issued with `prog_en` = 1.
  - VERIFY runs for `CHAIN_LEN` cycles with `prog_en` = 1. `ccff_head` is driven combinationally from `ccff_tail` so the chain rotates and its contents are preserved.
  - A second CRC accumulates `ccff_tail` on each of these cycles.
  - At the end, `err` = (CRC_load ≠ CRC_rot), then → DONE.
  - Load-to-`done` latency becomes 2·`CHAIN_LEN` + 1 cycles.
- Undefined: no VERIFY state, no CRC logic, and `err` is tied 0.

## Structure
- Package `ccff_loader_pkg`:
  - state enum;
  - `CRC16_POLY`, `CRC16_INIT` constants;
  - a bit-count width helper.
- Sub-module `ccff_crc16`: 1-bit-per-cycle serial CRC with `clr`/`en`/`din` inputs. It is instantiated twice when `CCFF_READBACK_EN` is defined.

## Test plan
- Basic load, `CHAIN_LEN`=20: bytes 0xA5, 0x3C, 0xF0 sent back-to-back. Chain model ends holding 1010_0101_0011_1100_1111. `prog_en` is high exactly 20 cycles. `done` rises 21 cycles after `start`. Byte 0xF0's low nibble is discarded.
- Stall: drop `byte_valid` for 5 cycles mid-second-byte. `prog_en` is 0 for exactly those cycles and the final chain contents match the basic case.
- Abort/reset: `abort` after 9 bits. Next cycle: IDLE, `prog_en` = 0, `busy` = 0. A subsequent `start` plus a full load yields correct contents. Repeat the same using `RST`.
- Ignored start: pulse `start` during LOAD. There is no counter reset and the load completes normally.
- Readback (`CCFF_READBACK_EN`): after a correct load, `err` = 0, `done` rises at cycle 41 and the chain contents are unchanged. With the bench flipping chain bit 7 before VERIFY, `err` = 1.
- Back-to-back loads: `start` in DONE with bitstream 0x00×3. The chain is all zero and `err` is cleared.
